// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: shares the single register-file write port between NUM_REQ
// writeback sources with round-robin valid/ready arbitration and a registered write.
// Optional feature macro RF_INIT_CLEAR_EN: after reset, sweep x1..x31 with zeros
// before any requester is served.
module reg_file_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_write_addr,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic [PTR_W-1:0]          grant_id,
    output logic                      init_busy
);

    logic [PTR_W-1:0]  rr_ptr_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [PTR_W-1:0]  gid_q;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;
    logic               run;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

`ifdef RF_INIT_CLEAR_EN
    localparam logic [0:0]        StInit       = 1'b0;
    localparam logic [0:0]        StRun        = 1'b1;
    localparam logic [ADDR_W-1:0] LastInitAddr = ADDR_W'(31);

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] init_cnt_q;

    assign run       = (state_q == StRun);
    assign init_busy = reset & ~run;

    // Sweep sequencer: walk init_cnt 1..31, then hand over to RUN until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            init_cnt_q <= ADDR_W'(1);
        end else if (state_q == StInit) begin
            if (init_cnt_q == LastInitAddr) begin
                state_q <= StRun;
            end else begin
                init_cnt_q <= init_cnt_q + ADDR_W'(1);
            end
        end
    end
`else
    assign run       = 1'b1;
    assign init_busy = 1'b0;
`endif

    // Round-robin search starting one past the last winner; ready is forced low in
    // reset and during the sweep so no handshake can complete then.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        cand_idx   = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any          = 1'b1;
                grant[cand_idx]    = 1'b1;
                grant_idx          = cand_idx;
                grant_addr         = addr_arr[cand_idx];
                grant_data         = data_arr[cand_idx];
            end
        end
        if (!run || !reset) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant;

    // Registered write port: sweep write, accepted request (x0 suppressed), or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            gid_q    <= '0;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
`ifdef RF_INIT_CLEAR_EN
        end else if (!run) begin
            we_q   <= 1'b1;
            addr_q <= init_cnt_q;
            data_q <= '0;
`endif
        end else if (grant_any) begin
            we_q     <= (grant_addr != '0);
            addr_q   <= grant_addr;
            data_q   <= grant_data;
            gid_q    <= grant_idx;
            rr_ptr_q <= grant_idx;
        end else begin
            we_q <= 1'b0;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = addr_q;
    assign rf_write_data   = data_q;
    assign grant_id        = gid_q;

endmodule
